// File: rtl/button_evt_pkg.sv
// -----------------------------------------------------------------------------
// button_evt_pkg
//  Shared definitions for the push-button gesture classifier:
//   - state_t        : gesture FSM encoding
//   - DEF_*_CNT      : default cycle counts for a 50 MHz system clock
//   - max3()         : helper used to size the gesture timer
// -----------------------------------------------------------------------------
package button_evt_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESSED   = 3'd1,
      LONG_HELD = 3'd2,
      WAIT_DBL  = 3'd3,
      SECOND    = 3'd4
   } state_t;

   // 1 s long press, 250 ms double-click window, 100 ms auto-repeat @ 50 MHz
   localparam int unsigned DEF_LONG_CNT   = 50_000_000;
   localparam int unsigned DEF_DBL_CNT    = 12_500_000;
   localparam int unsigned DEF_REPEAT_CNT = 5_000_000;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_event_level_edge.sv
// -----------------------------------------------------------------------------
// level_edge
//  Edge detector with an arming gate for the debounced button level.
//  The debouncer comes out of reset at 0, which reads as "pressed" on
//  active-low boards, so nothing is reported until the idle level has been
//  seen at least once.
//
//  Ports
//   clk           in  system clock
//   rst           in  synchronous reset, active-high
//   btn_level     in  debounced, clk-synchronous button level
//   press_edge    out combinational: idle->pressed change this cycle (armed only)
//   release_edge  out combinational: pressed->idle change this cycle (armed only)
//   active        out combinational: armed and level currently pressed
// -----------------------------------------------------------------------------
module level_edge #(
   parameter logic PRESS_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic press_edge,
   output logic release_edge,
   output logic active
);

   logic prev_level;
   logic armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_level <= ~PRESS_LEVEL;
         armed      <= 1'b0;
      end else begin
         prev_level <= btn_level;
         if (btn_level != PRESS_LEVEL)
            armed <= 1'b1;
      end
   end

   // The arming cycle itself sees prev=pressed, level=idle; armed is still 0
   // there, so no spurious release is produced.
   assign press_edge   = armed && (prev_level != PRESS_LEVEL) && (btn_level == PRESS_LEVEL);
   assign release_edge = armed && (prev_level == PRESS_LEVEL) && (btn_level != PRESS_LEVEL);
   assign active       = armed && (btn_level == PRESS_LEVEL);

endmodule

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//  Classifies debounced button gestures into single-cycle event pulses:
//  press, release, short click, long press, double click and auto-repeat.
//  All outputs are registered and appear the cycle after the condition that
//  triggers them.
//
//  Parameters
//   PRESS_LEVEL  level meaning "pressed" (0 for active-low keys)
//   LONG_CNT     hold cycles for a long press            (>= 2)
//   DBL_CNT      max release gap for a double click      (>= 2)
//   REPEAT_CNT   auto-repeat period while long-held      (>= 2)
//   DBL_EN       0: no double-click, short reported at release
//
//  Ports
//   clk, rst       clock / synchronous active-high reset
//   btn_level      debounced, already synchronous level
//   held           1 while armed and pressed
//   press_pulse    idle->pressed edge
//   release_pulse  pressed->idle edge
//   short_pulse    single short click
//   long_pulse     hold reached LONG_CNT
//   double_pulse   second click released within window
//   repeat_pulse   every REPEAT_CNT cycles after long_pulse while held
// -----------------------------------------------------------------------------
module button_event
   import button_evt_pkg::*;
#(
   parameter logic        PRESS_LEVEL = 1'b0,
   parameter int unsigned LONG_CNT    = DEF_LONG_CNT,
   parameter int unsigned DBL_CNT     = DEF_DBL_CNT,
   parameter int unsigned REPEAT_CNT  = DEF_REPEAT_CNT,
   parameter bit          DBL_EN      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic held,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic double_pulse,
   output logic repeat_pulse
);

   localparam int unsigned CNT_MAX = max3(LONG_CNT, DBL_CNT, REPEAT_CNT);
   localparam int          TW      = $clog2(CNT_MAX + 1);

   localparam logic [TW-1:0] LONG_END   = TW'(LONG_CNT - 1);
   localparam logic [TW-1:0] DBL_END    = TW'(DBL_CNT - 1);
   localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_CNT - 1);
   localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};

   logic press_edge;
   logic release_edge;
   logic active;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          timer_clr;
   logic          short_nxt, long_nxt, double_nxt, repeat_nxt;

   level_edge #(
      .PRESS_LEVEL (PRESS_LEVEL)
   ) u_level_edge (
      .clk          (clk),
      .rst          (rst),
      .btn_level    (btn_level),
      .press_edge   (press_edge),
      .release_edge (release_edge),
      .active       (active)
   );

   // Next-state and event decode. Edges are tested before timer terminals so
   // that an edge landing on a terminal cycle takes priority.
   always_comb begin
      state_nxt  = state;
      timer_clr  = 1'b0;
      short_nxt  = 1'b0;
      long_nxt   = 1'b0;
      double_nxt = 1'b0;
      repeat_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            if (press_edge)
               state_nxt = PRESSED;
         end
         PRESSED: begin
            if (release_edge) begin
               if (DBL_EN) begin
                  state_nxt = WAIT_DBL;
               end else begin
                  short_nxt = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (timer == LONG_END) begin
               long_nxt  = 1'b1;
               state_nxt = LONG_HELD;
            end
         end
         LONG_HELD: begin
            if (release_edge) begin
               state_nxt = IDLE;
            end else if (timer == REPEAT_END) begin
               repeat_nxt = 1'b1;
               timer_clr  = 1'b1;
            end
         end
         WAIT_DBL: begin
            if (press_edge) begin
               state_nxt = SECOND;
            end else if (timer == DBL_END) begin
               short_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         SECOND: begin
            if (release_edge) begin
               double_nxt = 1'b1;
               state_nxt  = IDLE;
            end else if (timer == LONG_END) begin
               // First click already counted as a short; second turned long.
               short_nxt = 1'b1;
               long_nxt  = 1'b1;
               state_nxt = LONG_HELD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Timer restarts on every state change; otherwise counts and saturates.
      if ((state_nxt != state) || timer_clr)
         timer_nxt = '0;
      else if (timer != TIMER_SAT)
         timer_nxt = timer + 1'b1;
      else
         timer_nxt = timer;
   end

   // Register stage: state, timer and all event outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         held          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         double_pulse  <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         held          <= active;
         press_pulse   <= press_edge;
         release_pulse <= release_edge;
         short_pulse   <= short_nxt;
         long_pulse    <= long_nxt;
         double_pulse  <= double_nxt;
         repeat_pulse  <= repeat_nxt;
      end
   end

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//  Scoreboard bench for button_event (LONG_CNT=20, DBL_CNT=8, REPEAT_CNT=5,
//  active-low button). Stimulus pushes expected pulse vectors and held
//  values, tagged with the cycle they must appear on; a monitor on the
//  falling edge pops and compares them against the DUT.
//  Pulse vector bit order: {repeat, double, long, short, release, press}.
// -----------------------------------------------------------------------------
module tb_button_event;

   localparam logic [5:0] EP  = 6'b000001;
   localparam logic [5:0] ER  = 6'b000010;
   localparam logic [5:0] ES  = 6'b000100;
   localparam logic [5:0] EL  = 6'b001000;
   localparam logic [5:0] ED  = 6'b010000;
   localparam logic [5:0] ERP = 6'b100000;

   logic clk = 1'b0;
   logic rst;
   logic btn_level;
   logic held, press_pulse, release_pulse, short_pulse;
   logic long_pulse, double_pulse, repeat_pulse;

   button_event #(
      .PRESS_LEVEL (1'b0),
      .LONG_CNT    (20),
      .DBL_CNT     (8),
      .REPEAT_CNT  (5),
      .DBL_EN      (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_level     (btn_level),
      .held          (held),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_pulse   (short_pulse),
      .long_pulse    (long_pulse),
      .double_pulse  (double_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [5:0] m;
   } pexp_t;

   typedef struct {
      int   c;
      logic h;
      bit   quiet;
   } hexp_t;

   pexp_t pq[$];
   hexp_t hq[$];

   int checks = 0;
   int errors = 0;
   bit done = 1'b0;
   bit final_done = 1'b0;
   int t0;

   logic [5:0] got;
   pexp_t      pe;
   hexp_t      he;

   // Monitor / scoreboard
   always @(negedge clk) begin
      got = {repeat_pulse, double_pulse, long_pulse, short_pulse, release_pulse, press_pulse};

      while (pq.size() > 0 && pq[0].c < cyc) begin
         pe = pq.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_pulse cyc=%0d got=none required=%b", pe.c, pe.m);
      end

      if (got != 6'b0) begin
         checks++;
         if (pq.size() == 0 || pq[0].c != cyc) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got=%b required=000000", cyc, got);
         end else begin
            pe = pq.pop_front();
            if (pe.m != got) begin
               errors++;
               $display("FAIL pulse_vector cyc=%0d got=%b required=%b", cyc, got, pe.m);
            end
         end
      end

      while (hq.size() > 0 && hq[0].c < cyc) begin
         he = hq.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_held_check cyc=%0d", he.c);
      end

      if (hq.size() > 0 && hq[0].c == cyc) begin
         he = hq.pop_front();
         checks++;
         if (held !== he.h || (he.quiet && got != 6'b0)) begin
            errors++;
            $display("FAIL held_quiet cyc=%0d got held=%b pulses=%b required held=%b quiet=%0d",
                     cyc, held, got, he.h, he.quiet);
         end
      end

      if (done && !final_done) begin
         final_done = 1'b1;
         checks++;
         if (pq.size() != 0 || hq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got pulses=%0d held=%0d required 0 0",
                     pq.size(), hq.size());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expp(input int off, input logic [5:0] m);
      pexp_t e;
      e.c = t0 + off;
      e.m = m;
      pq.push_back(e);
   endtask

   task automatic exph(input int off, input logic h, input bit quiet);
      hexp_t e;
      e.c   = t0 + off;
      e.h   = h;
      e.quiet = quiet;
      hq.push_back(e);
   endtask

   task automatic quiet_span(input int from, input int to);
      for (int i = from; i <= to; i++) exph(i, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      btn_level = 1'b0;

      // Reset held with the debouncer's reset level (reads as pressed)
      t0 = 0;
      quiet_span(1, 10);
      tick(10);

      // Out of reset, still pressed level: disarmed, silent
      rst = 1'b0;
      t0  = cyc;
      quiet_span(1, 5);
      tick(5);

      // Idle level arms the block without producing events
      btn_level = 1'b1;
      t0 = cyc;
      quiet_span(1, 3);
      tick(4);

      // Short click: press 6, release, short after the double window
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      exph(3, 1'b1, 1'b0);
      expp(7, ER);
      exph(8, 1'b0, 1'b0);
      expp(15, ES);
      tick(6);
      btn_level = 1'b1;
      tick(14);

      // Double click
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(4, ER);
      expp(7, EP);
      expp(10, ER | ED);
      tick(3);
      btn_level = 1'b1;
      tick(3);
      btn_level = 1'b0;
      tick(3);
      btn_level = 1'b1;
      tick(14);

      // Long hold with auto-repeat
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(21, EL);
      exph(30, 1'b1, 1'b0);
      expp(26, ERP);
      expp(31, ERP);
      expp(36, ERP);
      expp(41, ERP);
      expp(42, ER);
      tick(41);
      btn_level = 1'b1;
      tick(12);

      // Release coincides with long terminal: edge wins, short later
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(21, ER);
      expp(29, ES);
      tick(20);
      btn_level = 1'b1;
      tick(12);

      // One cycle longer: long fires, release gives no short
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(21, EL);
      expp(22, ER);
      tick(21);
      btn_level = 1'b1;
      tick(12);

      // Second click held long: short and long together
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(4, ER);
      expp(7, EP);
      expp(27, ES | EL);
      expp(31, ER);
      tick(3);
      btn_level = 1'b1;
      tick(3);
      btn_level = 1'b0;
      tick(24);
      btn_level = 1'b1;
      tick(12);

      // Reset during LONG_HELD, button kept pressed through and after reset
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(21, EL);
      tick(23);
      rst = 1'b1;
      quiet_span(24, 25);
      tick(2);
      rst = 1'b0;
      quiet_span(26, 35);
      tick(10);
      btn_level = 1'b1;
      quiet_span(36, 38);
      tick(4);

      // Re-armed: a short click works again
      t0 = cyc;
      btn_level = 1'b0;
      expp(1, EP);
      expp(3, ER);
      expp(11, ES);
      tick(2);
      btn_level = 1'b1;
      tick(14);

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
